// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller and the pipeline
// register muxes that consume its outputs:
//   - hz_state_e   : hazard FSM state encoding (also exported on state_o)
//   - ctrl_bits_t  : the ID_EX control bits that a bubble forces to zero
//   - hz_ctrl_t    : bundle of enables / bubble / flush controls
//   - CTRL_*       : the four control patterns the controller can emit
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_STALL_LU = 2'd1,
      ST_WAIT_MEM = 2'd2,
      ST_FLUSH    = 2'd3
   } hz_state_e;

   // ID_EX control bits cleared when id_ex_bubble is asserted.
   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic branch;
   } ctrl_bits_t;

   localparam ctrl_bits_t BUBBLE_CTRL = '0;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic id_ex_bubble;
      logic if_id_flush;
      logic ex_mem_flush;
   } hz_ctrl_t;

   // Normal flow: everything advances, nothing is killed.
   localparam hz_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   // Data memory busy: the whole pipe holds still.
   localparam hz_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   // Taken branch in MEM: advance, but kill the three younger instructions.
   localparam hz_ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   // Load-use: hold PC and IF_ID, push a bubble into ID_EX, let EX/MEM drain.
   localparam hz_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that counts up by one per cycle of inc and sticks at all-ones.
// Ports:
//   clk   in   rising-edge clock
//   clr   in   synchronous clear (has priority over inc)
//   inc   in   count this cycle
//   count out  current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Generates pipeline register enables, the ID_EX control bubble and the
// IF_ID / EX_MEM flushes for a 5-stage pipeline, and counts hazard events.
// Controls are combinational (same-cycle) from inputs and the FSM state.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt source registers of the instruction in ID
//   ex_MemRead, ex_rt        load-in-EX flag and its destination (from ID_EX)
//   mem_branch_tk            branch in MEM resolved taken
//   mem_req, mem_ready       data-memory handshake of the MEM stage
//   pc_en .. ex_mem_en       per-stage register enables
//   id_ex_bubble             zero the ID_EX control inputs
//   if_id_flush/ex_mem_flush clear IF_ID / EX_MEM control
//   state_o                  FSM state (debug)
//   stall_cnt/flush_cnt/wait_cnt_tot  saturating event counters
//   mem_timeout              sticky: a memory wait ran past MAX_WAIT
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 15,
   parameter int WAIT_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_MemRead,
   input  logic [4:0]       ex_rt,
   input  logic             mem_branch_tk,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic             ex_mem_flush,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] wait_cnt_tot,
   output logic             mem_timeout
);

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

   hz_state_e         state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              timeout_q, timeout_d;

   logic              cond_w, cond_b, cond_l;
   logic              rs_hit, rt_hit;
   hz_ctrl_t          ctrl;

   // Hazard detection with fixed priority: memory wait, then taken branch,
   // then load-use.
   always_comb begin
      cond_w = mem_req & ~mem_ready;
      cond_b = mem_branch_tk & ~cond_w;
      rs_hit = (ex_rt == id_rs);
      rt_hit = id_uses_rt & (ex_rt == id_rt);
      // The cycle after a flush, ID holds a killed NOP, so its register
      // fields must not raise a stall. $zero is never a real dependency.
      cond_l = ex_MemRead & (ex_rt != 5'd0) & (rs_hit | rt_hit)
             & ~cond_w & ~cond_b & (state_q != ST_FLUSH);
   end

   // Next state and wait tracking.
   always_comb begin
      state_d   = ST_RUN;
      wait_d    = '0;
      timeout_d = timeout_q;

      if (cond_w) begin
         state_d = ST_WAIT_MEM;
      end else if (cond_b) begin
         state_d = ST_FLUSH;
      end else if (cond_l) begin
         state_d = ST_STALL_LU;
      end

      // Wait length is only counted for cycles already spent in WAIT_MEM;
      // leaving WAIT_MEM drops it back to zero via the default above.
      if ((state_q == ST_WAIT_MEM) && cond_w) begin
         wait_d = (wait_q == WAIT_LIMIT) ? wait_q : wait_q + WAIT_W'(1);
         if (wait_d == WAIT_LIMIT) begin
            timeout_d = 1'b1;
         end
      end
   end

   // Mealy control outputs; during reset the pipe is left free-running.
   always_comb begin
      ctrl = CTRL_RUN;
      if (!rst) begin
         if (cond_w) begin
            ctrl = CTRL_FREEZE;
         end else if (cond_b) begin
            ctrl = CTRL_FLUSH;
         end else if (cond_l) begin
            ctrl = CTRL_STALL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (cond_l),
      .count (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (cond_b),
      .count (flush_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_wait_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (cond_w),
      .count (wait_cnt_tot)
   );

   assign pc_en        = ctrl.pc_en;
   assign if_id_en     = ctrl.if_id_en;
   assign id_ex_en     = ctrl.id_ex_en;
   assign ex_mem_en    = ctrl.ex_mem_en;
   assign id_ex_bubble = ctrl.id_ex_bubble;
   assign if_id_flush  = ctrl.if_id_flush;
   assign ex_mem_flush = ctrl.ex_mem_flush;
   assign state_o      = state_q;
   assign mem_timeout  = timeout_q;

endmodule
